cache_axi_arbiter: RTL and testbench

Merges the instruction-cache and data-cache miss traffic onto the single AXI master port of the core.
- Read channel: arbitrates between the icache (AR/R) and dcache (AR/R) requesters. Exactly one read burst is outstanding at a time.
- Write channel: forwards the dcache write-back (AW/W/B) and tracks one outstanding write.
- Sits directly downstream of both caches and upstream of the SoC AXI crossbar.

---
 rtl/cache_axi_arbiter.sv | 145 ++++++++++++++
 tb/tb_cache_axi_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: merges icache/dcache read misses and dcache write-backs onto one AXI master.
// Define ARB_RR_EN for round-robin read arbitration (default: fixed dcache-first).
module cache_axi_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int ICACHE_ID  = 0,
  parameter int DCACHE_ID  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  input  logic [7:0]            i_arlen,
  input  logic                  i_arvalid,
  output logic                  i_arready,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_rlast,
  output logic                  i_rvalid,
  input  logic                  i_rready,
  input  logic [ADDR_WIDTH-1:0] d_araddr,
  input  logic [7:0]            d_arlen,
  input  logic                  d_arvalid,
  output logic                  d_arready,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_rlast,
  output logic                  d_rvalid,
  input  logic                  d_rready,
  input  logic [ADDR_WIDTH-1:0] d_awaddr,
  input  logic [7:0]            d_awlen,
  input  logic [2:0]            d_awsize,
  input  logic                  d_awvalid,
  output logic                  d_awready,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [3:0]            d_wstrb,
  input  logic                  d_wlast,
  input  logic                  d_wvalid,
  output logic                  d_wready,
  output logic                  d_bvalid,
  input  logic                  d_bready,
  output logic [ID_WIDTH-1:0]   m_arid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic [ID_WIDTH-1:0]   m_awid,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [7:0]            m_awlen,
  output logic [2:0]            m_awsize,
  output logic [1:0]            m_awburst,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ID_WIDTH-1:0]   m_wid,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [3:0]            m_wstrb,
  output logic                  m_wlast,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic                  m_bvalid,
  output logic                  m_bready
);
  typedef enum logic [1:0] {R_IDLE, R_I, R_D} r_state_t;
  typedef enum logic {W_IDLE, W_BUSY} w_state_t;
  r_state_t r_rs, w_rs_nx;
  w_state_t r_ws, w_ws_nx;
  logic r_ar_done, r_aw_done, r_w_done;
  logic w_own_i, w_own_d, w_pick_d, w_ar_hs, w_r_end, w_idle, w_aw_hs, w_wl_hs, w_b_hs;
  assign w_own_i = r_rs == R_I;
  assign w_own_d = r_rs == R_D;
`ifdef ARB_RR_EN
  logic r_rr_last;  // 1: dcache held the last grant
  assign w_pick_d = d_arvalid & (~i_arvalid | ~r_rr_last);
  always_ff @(posedge clk)
    if (rst) r_rr_last <= 1'b0;
    else if (r_rs == R_IDLE && w_rs_nx != R_IDLE) r_rr_last <= w_pick_d;
`else
  assign w_pick_d = d_arvalid;
`endif
  assign m_arid    = w_own_d ? ID_WIDTH'(DCACHE_ID) : ID_WIDTH'(ICACHE_ID);
  assign m_araddr  = w_own_d ? d_araddr : i_araddr;
  assign m_arlen   = w_own_d ? d_arlen : i_arlen;
  assign m_arsize  = 3'b010;
  assign m_arburst = 2'b01;
  assign m_arvalid = ((w_own_d & d_arvalid) | (w_own_i & i_arvalid)) & ~r_ar_done;
  assign d_arready = w_own_d & m_arready & ~r_ar_done;
  assign i_arready = w_own_i & m_arready & ~r_ar_done;
  assign m_rready  = r_ar_done & ((w_own_d & d_rready) | (w_own_i & i_rready));
  assign d_rvalid  = w_own_d & r_ar_done & m_rvalid;
  assign i_rvalid  = w_own_i & r_ar_done & m_rvalid;
  assign d_rdata   = m_rdata;
  assign i_rdata   = m_rdata;
  assign d_rlast   = m_rlast;
  assign i_rlast   = m_rlast;
  assign w_ar_hs   = m_arvalid & m_arready;
  assign w_r_end   = m_rvalid & m_rready & m_rlast;
  always_comb
    w_rs_nx = r_rs == R_IDLE ? (w_pick_d ? R_D : i_arvalid ? R_I : R_IDLE) : (w_r_end ? R_IDLE : r_rs);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rs      <= R_IDLE;
      r_ar_done <= 1'b0;
    end else begin
      r_rs      <= w_rs_nx;
      r_ar_done <= (r_ar_done | w_ar_hs) & (w_rs_nx != R_IDLE);
    end
  end
  assign w_idle    = r_ws == W_IDLE;
  assign m_awid    = ID_WIDTH'(DCACHE_ID);
  assign m_awaddr  = d_awaddr;
  assign m_awlen   = d_awlen;
  assign m_awsize  = d_awsize;
  assign m_awburst = 2'b01;
  assign m_awvalid = w_idle & d_awvalid & ~r_aw_done;
  assign d_awready = w_idle & m_awready & ~r_aw_done;
  assign m_wid     = ID_WIDTH'(DCACHE_ID);
  assign m_wdata   = d_wdata;
  assign m_wstrb   = d_wstrb;
  assign m_wlast   = d_wlast;
  assign m_wvalid  = w_idle & d_wvalid & ~r_w_done;
  assign d_wready  = w_idle & m_wready & ~r_w_done;
  assign m_bready  = ~w_idle & d_bready;
  assign d_bvalid  = ~w_idle & m_bvalid;
  assign w_aw_hs   = m_awvalid & m_awready;
  assign w_wl_hs   = m_wvalid & m_wready & d_wlast;
  assign w_b_hs    = m_bvalid & m_bready;
  // AW and the last W beat may complete in either order; both are needed before waiting on B
  always_comb
    w_ws_nx = w_idle ? (((r_aw_done | w_aw_hs) & (r_w_done | w_wl_hs)) ? W_BUSY : W_IDLE) : (w_b_hs ? W_IDLE : W_BUSY);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ws      <= W_IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_ws      <= w_ws_nx;
      r_aw_done <= ~w_b_hs & (r_aw_done | w_aw_hs);
      r_w_done  <= ~w_b_hs & (r_w_done | w_wl_hs);
    end
  end
endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb_cache_axi_arbiter: randomized + directed scoreboard bench with memory/slave models for the arbiter.
module tb_cache_axi_arbiter;
  logic clk = 1'b0, rst;
  logic [31:0] i_araddr, d_araddr, d_awaddr, d_wdata, i_rdata, d_rdata, m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [7:0] i_arlen, d_arlen, d_awlen, m_arlen, m_awlen;
  logic [2:0] d_awsize, m_arsize, m_awsize;
  logic [3:0] d_wstrb, m_wstrb, m_arid, m_awid, m_wid;
  logic [1:0] m_arburst, m_awburst;
  logic i_arvalid, i_arready, i_rlast, i_rvalid, i_rready;
  logic d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
  logic d_awvalid, d_awready, d_wlast, d_wvalid, d_wready, d_bvalid, d_bready;
  logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

  always #5 clk = ~clk;

  cache_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize), .d_awvalid(d_awvalid), .d_awready(d_awready),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast), .d_wvalid(d_wvalid), .d_wready(d_wready),
    .d_bvalid(d_bvalid), .d_bready(d_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  typedef struct packed {logic [31:0] data; logic last;} beat_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} wbeat_t;
  typedef struct packed {logic [31:0] addr; logic [7:0] len; logic [2:0] size;} aw_t;
  beat_t exp_i[$], exp_d[$];
  wbeat_t exp_w[$];
  aw_t exp_aw[$];
  int n_vec = 0, n_bad = 0;
  int rd_open = 0, wr_open = 0, ar_cnt = 0, aw_cnt = 0, wl_cnt = 0, n_rd = 0;
  int hold_d = 0, bdelay = 2;
  bit rdy_rand = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // memory contents seen through the slave: a function of address, beat and requester id
  function automatic logic [31:0] rd_data(input logic [31:0] a, input int id, input int k);
    return a + 32'(k * 4) + (32'(id) << 24);
  endfunction

  function automatic bit tie_winner_d(input bit last_d);
`ifdef ARB_RR_EN
    return !last_d;
`else
    return last_d | 1'b1;
`endif
  endfunction

  // read slave: one burst at a time, random AR/R delays, beats held until accepted
  initial begin
    bit s_act, ar_f, r_f, rs, arv;
    int s_k, s_id, cap_id;
    logic [7:0] s_len, cap_l;
    logic [31:0] s_a, cap_a;
    s_act = 0; s_k = 0; s_id = 0; s_len = 0; s_a = 0;
    m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = 0;
    forever begin
      @(negedge clk);
      rs = rst; arv = m_arvalid; ar_f = m_arvalid && m_arready; r_f = m_rvalid && m_rready;
      cap_a = m_araddr; cap_l = m_arlen; cap_id = int'(m_arid);
      @(posedge clk); #1;
      if (rs) begin
        s_act = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0;
      end else begin
        if (ar_f) begin s_act = 1; s_k = 0; s_a = cap_a; s_len = cap_l; s_id = cap_id; end
        if (r_f) begin s_k++; m_rvalid = 0; if (s_k > int'(s_len)) s_act = 0; end
        m_arready = !s_act && arv && ($urandom_range(0, 1) == 1);
        if (s_act && !m_rvalid && $urandom_range(0, 3) != 0) begin
          m_rvalid = 1; m_rdata = rd_data(s_a, s_id, s_k); m_rlast = s_k == int'(s_len);
        end
      end
    end
  end

  // write slave: random AW/W ready, B returned bdelay cycles after both AW and last W
  initial begin
    bit got_aw, got_w, awv, wv, awf, wf, bf, rs;
    int cnt;
    got_aw = 0; got_w = 0; cnt = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0;
    forever begin
      @(negedge clk);
      rs = rst; awv = m_awvalid; wv = m_wvalid; awf = m_awvalid && m_awready;
      wf = m_wvalid && m_wready && m_wlast; bf = m_bvalid && m_bready;
      @(posedge clk); #1;
      if (rs) begin
        got_aw = 0; got_w = 0; cnt = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
      end else begin
        got_aw |= awf; got_w |= wf;
        if (bf) begin m_bvalid = 0; got_aw = 0; got_w = 0; cnt = 0; end
        else if (got_aw && got_w && !m_bvalid) begin if (cnt == bdelay) m_bvalid = 1; cnt++; end
        m_awready = !got_aw && awv && ($urandom_range(0, 1) == 1);
        m_wready = !got_w && wv && ($urandom_range(0, 2) != 0);
      end
    end
  end

  initial begin
    i_rready = 1; d_rready = 1;
    forever begin
      @(posedge clk); #1;
      i_rready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      d_rready = hold_d > 0 ? 1'b0 : rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (hold_d > 0) hold_d--;
    end
  end

  // monitor: pops the scoreboard whenever a handshake is presented
  initial begin
    beat_t b;
    wbeat_t w;
    aw_t a;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_open = 0; wr_open = 0;
      end else begin
        if (m_arvalid && m_arready) begin chk("one_rd_out", 32'(rd_open), 0); rd_open++; ar_cnt++; end
        if (m_rvalid && m_rready && m_rlast) rd_open--;
        if (i_rvalid && i_rready) begin
          if (exp_i.size() == 0) begin n_vec++; n_bad++; $display("FAIL i_r_unexp: got beat %h expected none", i_rdata); end
          else begin b = exp_i.pop_front(); chk("i_rdata", i_rdata, b.data); chk("i_rlast", 32'(i_rlast), 32'(b.last)); end
        end
        if (d_rvalid && d_rready) begin
          if (exp_d.size() == 0) begin n_vec++; n_bad++; $display("FAIL d_r_unexp: got beat %h expected none", d_rdata); end
          else begin b = exp_d.pop_front(); chk("d_rdata", d_rdata, b.data); chk("d_rlast", 32'(d_rlast), 32'(b.last)); end
        end
        if (i_rvalid && d_rvalid) chk("r_excl", 32'({i_rvalid, d_rvalid}), 32'b01);
        if (m_awvalid && m_awready) begin
          chk("one_wr_out", 32'(wr_open), 0); wr_open++; aw_cnt++;
          if (exp_aw.size() == 0) begin n_vec++; n_bad++; $display("FAIL aw_unexp: got %h expected none", m_awaddr); end
          else begin
            a = exp_aw.pop_front();
            chk("awaddr", m_awaddr, a.addr); chk("awlen", 32'(m_awlen), 32'(a.len));
            chk("awsize", 32'(m_awsize), 32'(a.size)); chk("awid_burst", 32'({m_awid, m_awburst}), 32'({4'd1, 2'b01}));
          end
        end
        if (m_wvalid && m_wready) begin
          if (m_wlast) wl_cnt++;
          if (exp_w.size() == 0) begin n_vec++; n_bad++; $display("FAIL w_unexp: got %h expected none", m_wdata); end
          else begin
            w = exp_w.pop_front();
            chk("wdata", m_wdata, w.data); chk("wstrb_last_id", 32'({m_wstrb, m_wlast, m_wid}), 32'({w.strb, w.last, 4'd1}));
          end
        end
        if (m_bvalid && m_bready) wr_open--;
        if (m_bvalid || d_bvalid) begin
          chk("b_mirror", 32'(d_bvalid), 32'(m_bvalid)); chk("bready_pass", 32'(m_bready), 32'(d_bready));
        end
      end
    end
  end

  task automatic issue_ar(input bit is_d, input logic [31:0] a, input logic [7:0] len);
    bit got = 0;
    if (is_d) begin d_araddr = a; d_arlen = len; d_arvalid = 1; end
    else begin i_araddr = a; i_arlen = len; i_arvalid = 1; end
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk);
      got = is_d ? (d_arvalid && d_arready) : (i_arvalid && i_arready);
    end
    chk(is_d ? "d_ar_grant" : "i_ar_grant", 32'(got), 1);
    if (got) begin
      n_rd++;
      for (int k = 0; k <= int'(len); k++)
        if (is_d) exp_d.push_back('{rd_data(a, 1, k), k == int'(len)});
        else exp_i.push_back('{rd_data(a, 0, k), k == int'(len)});
    end
    @(posedge clk); #1;
    if (is_d) d_arvalid = 0; else i_arvalid = 0;
  endtask

  task automatic write_back(input logic [31:0] a, input logic [7:0] len, input int aw_dly, input int w_dly);
    bit got_b = 0;
    fork
      begin
        bit got = 0;
        repeat (aw_dly) begin @(posedge clk); #1; end
        d_awaddr = a; d_awlen = len; d_awsize = 3'($urandom_range(0, 2)); d_awvalid = 1;
        exp_aw.push_back('{a, len, d_awsize});
        for (int c = 0; c < 500 && !got; c++) begin @(negedge clk); got = d_awvalid && d_awready; end
        chk("aw_accept", 32'(got), 1);
        @(posedge clk); #1; d_awvalid = 0;
      end
      begin
        repeat (w_dly) begin @(posedge clk); #1; end
        for (int k = 0; k <= int'(len); k++) begin
          bit got = 0;
          d_wdata = $urandom; d_wstrb = 4'($urandom); d_wlast = k == int'(len); d_wvalid = 1;
          exp_w.push_back('{d_wdata, d_wstrb, d_wlast});
          for (int c = 0; c < 500 && !got; c++) begin @(negedge clk); got = d_wvalid && d_wready; end
          chk("w_accept", 32'(got), 1);
          @(posedge clk); #1;
        end
        d_wvalid = 0; d_wlast = 0;
      end
    join
    d_bready = 1;
    for (int c = 0; c < 500 && !got_b; c++) begin @(negedge clk); got_b = d_bvalid && d_bready; end
    chk("b_resp", 32'(got_b), 1);
    @(posedge clk); #1; d_bready = 0;
  endtask

  task automatic drain();
    for (int c = 0; c < 4000 && (exp_i.size() + exp_d.size() + exp_w.size() + exp_aw.size() + rd_open + wr_open) != 0; c++)
      @(negedge clk);
    chk("drain", 32'(exp_i.size() + exp_d.size() + exp_w.size() + exp_aw.size()), 0);
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic lat_check(input string nm, input logic [3:0] id, input logic [31:0] a);
    @(negedge clk); chk({nm, "_idle"}, 32'(m_arvalid), 0);
    @(negedge clk); chk({nm, "_arvalid"}, 32'(m_arvalid), 1);
    chk({nm, "_arid"}, 32'(m_arid), 32'(id)); chk({nm, "_araddr"}, m_araddr, a);
    chk({nm, "_size_burst"}, 32'({m_arsize, m_arburst}), 32'({3'b010, 2'b01}));
  endtask

  initial begin
    bit last_d, win_d;
    int aw0, w0;
    rst = 1;
    i_araddr = 0; i_arlen = 0; i_arvalid = 0; d_araddr = 0; d_arlen = 0; d_arvalid = 0;
    d_awaddr = 0; d_awlen = 0; d_awsize = 0; d_awvalid = 0; d_wdata = 0; d_wstrb = 0; d_wlast = 0; d_wvalid = 0; d_bready = 0;
    repeat (3) @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("reset_outs", 32'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, i_arready, d_arready,
                           i_rvalid, d_rvalid, d_awready, d_wready, d_bvalid}), 0);
    @(posedge clk); #1;
    fork issue_ar(0, 32'hBFC0_0000, 3); lat_check("i_alone", 4'd0, 32'hBFC0_0000); join
    drain();
    fork issue_ar(1, 32'h8000_0100, 1); lat_check("d_alone", 4'd1, 32'h8000_0100); join
    drain();
    last_d = 1;
    for (int t = 0; t < 2; t++) begin
      win_d = tie_winner_d(last_d);
      fork
        issue_ar(0, 32'hBFC0_0040 + 32'(t * 256), 3);
        issue_ar(1, 32'h8000_1000 + 32'(t * 256), 3);
        lat_check("tie", win_d ? 4'd1 : 4'd0, win_d ? 32'h8000_1000 + 32'(t * 256) : 32'hBFC0_0040 + 32'(t * 256));
      join
      drain();
      last_d = !win_d;
      if (t == 0) begin issue_ar(0, 32'hBFC0_0800, 0); drain(); last_d = 0; end
    end
    fork
      issue_ar(1, 32'h8000_3000, 7);
      begin
        int seen = 0;
        for (int c = 0; c < 400 && seen < 2; c++) begin @(negedge clk); if (d_rvalid && d_rready) seen++; end
        hold_d = 3;
        repeat (3) begin @(negedge clk); chk("bp_m_rready", 32'(m_rready), 0); end
      end
    join
    drain();
    bdelay = 5; aw0 = aw_cnt; w0 = wl_cnt;
    write_back(32'h8000_2000, 0, 1, 0);
    drain();
    chk("wb_one_aw", 32'(aw_cnt - aw0), 1); chk("wb_one_wlast", 32'(wl_cnt - w0), 1);
    bdelay = 9;
    fork issue_ar(1, 32'h8000_4000, 7); write_back(32'h8000_5000, 3, 0, 2); join
    drain();
    fork
      issue_ar(0, 32'hBFC0_0100, 3);
      begin
        int seen = 0;
        for (int c = 0; c < 400 && seen < 1; c++) begin @(negedge clk); if (i_rvalid && i_rready) seen++; end
      end
    join
    @(posedge clk); #1;
    rst = 1; exp_i.delete();
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("midrst_outs", 32'({m_arvalid, m_rready, i_rvalid, d_rvalid, m_awvalid, m_wvalid, d_bvalid}), 0);
    @(posedge clk); #1;
    fork issue_ar(0, 32'hBFC0_0200, 2); lat_check("post_rst", 4'd0, 32'hBFC0_0200); join
    drain();
    rdy_rand = 1;
    fork
      repeat (15) begin
        repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
        issue_ar(0, $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 7)));
      end
      repeat (15) begin
        repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
        issue_ar(1, $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 7)));
      end
      repeat (8) begin
        bdelay = $urandom_range(0, 6);
        write_back($urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 3)), $urandom_range(0, 2), $urandom_range(0, 2));
      end
    join
    drain();
    chk("ar_count", 32'(ar_cnt), 32'(n_rd));
    chk("aw_w_count", 32'(aw_cnt), 32'(wl_cnt));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
